// File: rtl/pio_pkg.sv
// pio_pkg: shared types for the PIO output-shift-register pull controller.
//   pull_state_e : pull FSM state encoding (RUN / WAIT_TX)
//   pull_op_e    : execute-stage op encoding on op_pull (OUT / PULL)
//   thr_map()    : maps a 5-bit threshold field to 6 bits, with 0 meaning 32
package pio_pkg;

  typedef enum logic [1:0] {
    PULL_RUN     = 2'd0,
    PULL_WAIT_TX = 2'd1
  } pull_state_e;

  typedef enum logic {
    OP_OUT  = 1'b0,
    OP_PULL = 1'b1
  } pull_op_e;

  localparam logic [5:0] THR_ZERO_MAP = 6'd32;

  function automatic logic [5:0] thr_map(input logic [4:0] t);
    return (t == 5'd0) ? THR_ZERO_MAP : {1'b0, t};
  endfunction

endpackage

// File: rtl/pio_pull_ctrl_if.sv
// pio_pull_ctrl_if: TX FIFO read port plus OSR control/status bundle.
//   tx_empty/tx_data/tx_pop          : TX FIFO head and pop strobe
//   osr_set/osr_din/osr_do_shift/
//   osr_shift                        : OSR load/shift controls
//   osr_count/osr_count_la           : OSR shift count and its lookahead
// master = pull controller, slave = FIFO/OSR side.
interface pio_pull_ctrl_if #(parameter int DW = 32);
  logic          tx_empty;
  logic [DW-1:0] tx_data;
  logic          tx_pop;
  logic          osr_set;
  logic [DW-1:0] osr_din;
  logic          osr_do_shift;
  logic [4:0]    osr_shift;
  logic [5:0]    osr_count;
  logic [5:0]    osr_count_la;

  modport master (
    input  tx_empty, tx_data, osr_count, osr_count_la,
    output tx_pop, osr_set, osr_din, osr_do_shift, osr_shift
  );

  modport slave (
    output tx_empty, tx_data, osr_count, osr_count_la,
    input  tx_pop, osr_set, osr_din, osr_do_shift, osr_shift
  );
endinterface

// File: rtl/pio_pull_ctrl.sv
// pio_pull_ctrl: OUT/PULL sequencing for one state machine's OSR.
// Decodes OUT/PULL from the execute stage, applies the autopull threshold,
// pops the TX FIFO and stalls the SM while a refill is pending.
// Ports:
//   clk, reset (sync, active-high)
//   penable, restart, ext_stall      : SM enable / restart / external stall
//   op_valid, op_pull, pull_block,
//   pull_ifempty, out_bits           : current OUT/PULL instruction
//   autopull_en, pull_thresh         : SHIFTCTRL fields (thresh 0 = 32)
//   x_reg                            : X value for non-blocking PULL on empty FIFO
//   bus (pio_pull_ctrl_if.master)    : TX FIFO read port + OSR controls
//   instr_stall                      : hold current instruction
//   state_o                          : FSM state (debug)
//   stall_cnt[15:0]                  : only with PIO_PULL_STALL_CNT_EN; saturating
//                                      count of enabled cycles spent in WAIT_TX
module pio_pull_ctrl
  import pio_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          penable,
  input  logic          restart,
  input  logic          ext_stall,
  input  logic          op_valid,
  input  logic          op_pull,
  input  logic          pull_block,
  input  logic          pull_ifempty,
  input  logic [4:0]    out_bits,
  input  logic          autopull_en,
  input  logic [4:0]    pull_thresh,
  input  logic [DW-1:0] x_reg,
  pio_pull_ctrl_if.master bus,
  output logic          instr_stall,
  output logic [1:0]    state_o
`ifdef PIO_PULL_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  pull_state_e state_q, state_d;
  logic [5:0]  thr;
  logic        osr_empty, la_empty, go, is_out;
  logic        pop_c, set_c, shift_c, stall_c, sel_x;

  assign thr       = thr_map(pull_thresh);
  assign osr_empty = bus.osr_count >= thr;
  assign la_empty  = bus.osr_count_la >= thr;
  assign go        = penable && !ext_stall;
  assign is_out    = (pull_op_e'(op_pull) == OP_OUT);

  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    set_c   = 1'b0;
    shift_c = 1'b0;
    stall_c = 1'b0;
    sel_x   = 1'b0;
    if (reset || restart) begin
      state_d = PULL_RUN;
    end else if (!go) begin
      stall_c = op_valid;
    end else if (!op_valid) begin
      // op withdrawn (e.g. while waiting): abandon the refill
      state_d = PULL_RUN;
    end else begin
      unique case (state_q)
        PULL_RUN: begin
          if (is_out) begin
            if (autopull_en && osr_empty) begin
              // refill first; OUT re-executes next cycle against a full OSR
              stall_c = 1'b1;
              if (!bus.tx_empty) begin
                pop_c = 1'b1;
                set_c = 1'b1;
              end else begin
                state_d = PULL_WAIT_TX;
              end
            end else begin
              shift_c = 1'b1;
              // lookahead autopull: reload in the same cycle as the final shift
              if (autopull_en && la_empty && !bus.tx_empty) begin
                pop_c = 1'b1;
                set_c = 1'b1;
              end
            end
          end else if (!(pull_ifempty && !osr_empty)) begin
            if (!bus.tx_empty) begin
              pop_c = 1'b1;
              set_c = 1'b1;
            end else if (!pull_block) begin
              set_c = 1'b1;
              sel_x = 1'b1;
            end else begin
              stall_c = 1'b1;
              state_d = PULL_WAIT_TX;
            end
          end
        end
        PULL_WAIT_TX: begin
          if (bus.tx_empty) begin
            stall_c = 1'b1;
          end else begin
            pop_c   = 1'b1;
            set_c   = 1'b1;
            state_d = PULL_RUN;
            // a PULL is finished by this load; an OUT still has to shift
            stall_c = is_out;
          end
        end
        default: state_d = PULL_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= PULL_RUN;
    else       state_q <= state_d;
  end

  assign bus.tx_pop       = pop_c;
  assign bus.osr_set      = set_c;
  assign bus.osr_do_shift = shift_c;
  assign bus.osr_shift    = out_bits;
  assign bus.osr_din      = sel_x ? x_reg : bus.tx_data;
  assign instr_stall      = stall_c;
  assign state_o          = state_q;

`ifdef PIO_PULL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // restart deliberately does not clear the counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (go && state_q == PULL_WAIT_TX && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pio_pull_ctrl.sv
// tb_pio_pull_ctrl: directed scenarios plus randomized cycles, every output
// compared against a behavioural model of the pull/autopull rules.
module tb_pio_pull_ctrl;
  logic        clk = 1'b0;
  logic        reset, penable, restart, ext_stall;
  logic        op_valid, op_pull, pull_block, pull_ifempty, autopull_en;
  logic [4:0]  out_bits, pull_thresh;
  logic [31:0] x_reg;
  logic        instr_stall;
  logic [1:0]  state_o;
`ifdef PIO_PULL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // model state: is a refill outstanding, and WAIT_TX cycle count
  bit m_wait;
  int m_cnt;

  always #5 clk = ~clk;

  pio_pull_ctrl_if #(.DW(32)) bus ();

  pio_pull_ctrl #(.DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .penable      (penable),
    .restart      (restart),
    .ext_stall    (ext_stall),
    .op_valid     (op_valid),
    .op_pull      (op_pull),
    .pull_block   (pull_block),
    .pull_ifempty (pull_ifempty),
    .out_bits     (out_bits),
    .autopull_en  (autopull_en),
    .pull_thresh  (pull_thresh),
    .x_reg        (x_reg),
    .bus          (bus.master),
    .instr_stall  (instr_stall),
    .state_o      (state_o)
`ifdef PIO_PULL_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected strobes for the current inputs, from the OUT/PULL rules.
  task automatic model(output bit pop, output bit set, output bit shf,
                       output bit stl, output logic [31:0] din, output bit nwait);
    int  thr;
    bit  go, empty, la_empty, fifo_ok;
    thr      = (pull_thresh == 0) ? 32 : int'(pull_thresh);
    empty    = int'(bus.osr_count) >= thr;
    la_empty = int'(bus.osr_count_la) >= thr;
    go       = penable && !ext_stall;
    fifo_ok  = !bus.tx_empty;
    pop = 0; set = 0; shf = 0; stl = 0; din = bus.tx_data; nwait = m_wait;
    if (reset || restart) begin
      nwait = 0;
      return;
    end
    if (!go) begin
      stl = op_valid;
      return;
    end
    if (!op_valid) begin
      nwait = 0;
      return;
    end
    if (m_wait) begin
      // waiting for a word: take it as soon as one appears
      pop = fifo_ok; set = fifo_ok;
      stl = !fifo_ok || !op_pull;
      nwait = !fifo_ok;
    end else if (!op_pull) begin
      if (autopull_en && empty) begin
        stl = 1; pop = fifo_ok; set = fifo_ok; nwait = !fifo_ok;
      end else begin
        shf = 1;
        pop = autopull_en && la_empty && fifo_ok;
        set = pop;
      end
    end else if (pull_ifempty && !empty) begin
      // nothing to do
    end else if (fifo_ok) begin
      pop = 1; set = 1;
    end else if (!pull_block) begin
      set = 1; din = x_reg;
    end else begin
      stl = 1; nwait = 1;
    end
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic step(input string tag);
    bit pop, set, shf, stl, nwait;
    logic [31:0] din;
    #1;
    model(pop, set, shf, stl, din, nwait);
    chk({tag, ".pop"},   32'(bus.tx_pop), 32'(pop));
    chk({tag, ".set"},   32'(bus.osr_set), 32'(set));
    chk({tag, ".shift"}, 32'(bus.osr_do_shift), 32'(shf));
    chk({tag, ".stall"}, 32'(instr_stall), 32'(stl));
    chk({tag, ".amt"},   32'(bus.osr_shift), 32'(out_bits));
    chk({tag, ".state"}, 32'(state_o), m_wait ? 32'd1 : 32'd0);
    if (set) chk({tag, ".din"}, bus.osr_din, din);
    if (bus.tx_pop && bus.tx_empty) chk({tag, ".pop_on_empty"}, 32'd1, 32'd0);
`ifdef PIO_PULL_STALL_CNT_EN
    chk({tag, ".scnt"}, 32'(stall_cnt), 32'(m_cnt));
`endif
    @(posedge clk);
    if (reset) m_cnt = 0;
    else if (penable && !ext_stall && m_wait && m_cnt < 65535) m_cnt++;
    m_wait = reset ? 1'b0 : nwait;
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; penable = 1; restart = 0; ext_stall = 0;
    op_valid = 0; op_pull = 0; pull_block = 0; pull_ifempty = 0;
    out_bits = 5'd8; autopull_en = 0; pull_thresh = 5'd0; x_reg = 32'h0;
    bus.tx_empty = 1; bus.tx_data = 32'h0;
    bus.osr_count = 6'd0; bus.osr_count_la = 6'd0;
  endtask

  initial begin
    m_wait = 0; m_cnt = 0;
    idle();
    reset = 1;
    op_valid = 1; bus.tx_empty = 0;
    @(negedge clk);
    step("reset");
    step("reset2");
    reset = 0;

    // autopull refill then shift
    autopull_en = 1; bus.osr_count = 6'd32; bus.osr_count_la = 6'd32;
    bus.tx_empty = 0; bus.tx_data = 32'hDEADBEEF; op_valid = 1; op_pull = 0;
    step("ap_refill");
    bus.osr_count = 6'd0; bus.osr_count_la = 6'd8;
    step("ap_shift");

    // lookahead autopull: shift and reload together
    bus.osr_count = 6'd24; bus.osr_count_la = 6'd32; bus.tx_data = 32'h12345678;
    step("ap_la");

    // blocking PULL, FIFO empty 5 cycles
    autopull_en = 0; op_pull = 1; pull_block = 1; bus.tx_empty = 1;
    bus.osr_count = 6'd0; bus.osr_count_la = 6'd0;
    for (int i = 0; i < 5; i++) step("bpull_wait");
    bus.tx_empty = 0; bus.tx_data = 32'hA5A5A5A5;
    step("bpull_pop");
`ifdef PIO_PULL_STALL_CNT_EN
    chk("bpull_cnt5", 32'(stall_cnt), 32'd5);
`endif
    chk("bpull_back_run", 32'(state_o), 32'd0);

    // non-blocking PULL on empty FIFO loads X
    pull_block = 0; bus.tx_empty = 1; x_reg = 32'h00C0FFEE;
    step("nbpull_x");

    // PULL IfEmpty
    pull_ifempty = 1; pull_thresh = 5'd16; bus.osr_count = 6'd8; bus.tx_empty = 0;
    step("ifempty_noop");
    bus.osr_count = 6'd16;
    step("ifempty_pop");
    pull_ifempty = 0;

    // restart while waiting
    pull_block = 1; bus.tx_empty = 1;
    step("rst_enter");
    step("rst_wait");
    restart = 1;
    step("rst_restart");
    restart = 0; op_valid = 0;
    step("rst_after");

    // external stall gates an OUT
    op_valid = 1; op_pull = 0; ext_stall = 1; autopull_en = 1;
    bus.osr_count = 6'd32; bus.tx_empty = 0;
    step("ext_stall");
    ext_stall = 0;

    // randomized cycles; op held while stalled
    for (int i = 0; i < 3000; i++) begin
      automatic bit hold = instr_stall && !restart && !reset;
      reset     = ($urandom_range(0, 199) == 0);
      restart   = ($urandom_range(0, 49) == 0);
      penable   = ($urandom_range(0, 15) != 0);
      ext_stall = ($urandom_range(0, 7) == 0);
      if (!hold) begin
        op_valid     = ($urandom_range(0, 5) != 0);
        op_pull      = $urandom_range(0, 1);
        pull_block   = $urandom_range(0, 1);
        pull_ifempty = $urandom_range(0, 1);
        out_bits     = 5'($urandom_range(0, 31));
      end
      autopull_en  = ($urandom_range(0, 3) != 0);
      pull_thresh  = 5'($urandom_range(0, 31));
      x_reg        = $urandom;
      bus.tx_empty = ($urandom_range(0, 2) == 0);
      bus.tx_data  = $urandom;
      bus.osr_count    = 6'($urandom_range(0, 32));
      bus.osr_count_la = 6'($urandom_range(int'(bus.osr_count), 32));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
